// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX serializer among N byte-stream requesters,
// round-robin at packet granularity, driving the serializer with a level start/busy handshake.
module uart_tx_arbiter #(
    parameter int unsigned N            = 4,
    parameter int unsigned IDW          = 2,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [7:0]     tx_data,
    output logic           tx_start,
    input  logic           tx_busy,
    output logic [IDW-1:0] grant_id,
    output logic           locked,
    output logic           lock_timeout
);

    localparam int unsigned    CW       = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CW-1:0]  TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [IDW-1:0] PTR_RST  = IDW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_start_q, tx_start_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic           locked_q, locked_d;
    logic           last_q, last_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           tmo_q, tmo_d;

    logic           owner_vld;
    logic           hi_vld, lo_vld;
    logic [IDW-1:0] hi_id, lo_id;
    logic           cand_vld;
    logic [IDW-1:0] cand_id;
    logic [7:0]     cand_data;
    logic           cand_last;
    logic           xfer;

    // Round-robin scan: first valid index above ptr_q, otherwise first at or below it.
    always_comb begin
        owner_vld = 1'b0;
        hi_vld    = 1'b0;
        hi_id     = '0;
        lo_vld    = 1'b0;
        lo_id     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_id_q == IDW'(i)) begin
                owner_vld = req_valid[i];
            end
            if (!hi_vld && req_valid[i] && (IDW'(i) > ptr_q)) begin
                hi_vld = 1'b1;
                hi_id  = IDW'(i);
            end
            if (!lo_vld && req_valid[i] && (IDW'(i) <= ptr_q)) begin
                lo_vld = 1'b1;
                lo_id  = IDW'(i);
            end
        end
    end

    always_comb begin
        cand_vld = 1'b0;
        cand_id  = '0;
        if (locked_q) begin
            cand_vld = owner_vld;
            cand_id  = grant_id_q;
        end else if (hi_vld) begin
            cand_vld = 1'b1;
            cand_id  = hi_id;
        end else if (lo_vld) begin
            cand_vld = 1'b1;
            cand_id  = lo_id;
        end
    end

    assign xfer = (state_q == IDLE) && !tx_busy && cand_vld;

    always_comb begin
        req_ready = '0;
        cand_data = '0;
        cand_last = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cand_id == IDW'(i)) begin
                req_ready[i] = xfer;
                cand_data    = req_data[8*i +: 8];
                cand_last    = req_last[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = tx_start_q;
        grant_id_d = grant_id_q;
        locked_d   = locked_q;
        last_d     = last_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        tmo_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    tx_data_d  = cand_data;
                    grant_id_d = cand_id;
                    last_d     = cand_last;
                    locked_d   = 1'b1;
                    tx_start_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = WAIT_BUSY;
                end else if (!locked_q) begin
                    cnt_d = '0;
                end else if (!owner_vld) begin
                    // An owner that goes quiet mid-packet loses the lock after the timeout.
                    if (cnt_q == TMO_LAST) begin
                        locked_d = 1'b0;
                        ptr_d    = grant_id_q;
                        tmo_d    = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                    if (last_q) begin
                        locked_d = 1'b0;
                        ptr_d    = grant_id_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            grant_id_q <= '0;
            locked_q   <= 1'b0;
            last_q     <= 1'b0;
            ptr_q      <= PTR_RST;
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            grant_id_q <= grant_id_d;
            locked_q   <= locked_d;
            last_q     <= last_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign grant_id     = grant_id_q;
    assign locked       = locked_q;
    assign lock_timeout = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized packet traffic checked against
// a packet-level round-robin model of the expected serializer byte order.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic [IDW-1:0] grant_id;
    logic           locked;
    logic           lock_timeout;

    int n_vec = 0;
    int n_err = 0;
    int mptr  = N - 1;

    logic [8:0] rq [N][$];
    logic [8:0] mq [N][$];
    int         exp_id[$];
    logic [8:0] exp_b[$];

    uart_tx_arbiter #(.N(N), .IDW(IDW), .LOCK_TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id),
        .locked       (locked),
        .lock_timeout (lock_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]       = v;
        req_data[8*i +: 8] = d;
        req_last[i]        = l;
    endtask

    // Serializer stand-in: busy rises dly cycles after the call, stays for hold cycles.
    task automatic serve(input int dly, input int hold);
        repeat (dly) tick();
        tx_busy = 1'b1;
        repeat (hold) tick();
        tx_busy = 1'b0;
        tick();
    endtask

    task automatic random_round();
        int         pick;
        int         nb;
        int         npk;
        int         len;
        int         obs;
        int         exp_n;
        int         cyc;
        int         ph;
        int         dly;
        int         hold;
        logic [7:0] cur;
        logic [8:0] b;
        logic [N-1:0] acc;

        for (int i = 0; i < N; i++) begin
            npk = $urandom_range(0, 3);
            for (int p = 0; p < npk; p++) begin
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) begin
                    b = {(k == len - 1), 8'($urandom_range(0, 255))};
                    rq[i].push_back(b);
                    mq[i].push_back(b);
                end
            end
        end

        // Expected order: whole packets, next owner is the first requester after the last owner still holding data.
        exp_id.delete();
        exp_b.delete();
        forever begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && mq[(mptr + k) % N].size() > 0) pick = (mptr + k) % N;
            end
            if (pick < 0) break;
            do begin
                b = mq[pick].pop_front();
                exp_id.push_back(pick);
                exp_b.push_back(b);
            end while (!b[8]);
            mptr = pick;
        end

        exp_n   = exp_b.size();
        obs     = 0;
        cyc     = 0;
        ph      = 0;
        dly     = 0;
        hold    = 0;
        cur     = '0;
        acc     = '0;
        tx_busy = 1'b0;
        while ((obs < exp_n || ph != 0) && cyc < 4000) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            end
            if (ph == 2) begin
                hold--;
                if (hold == 0) begin
                    tx_busy = 1'b0;
                    ph      = 0;
                end
            end else if (ph == 0 && tx_start) begin
                if (obs < exp_n) begin
                    check("rnd_byte", tx_data, exp_b[obs][7:0]);
                    check("rnd_grant", grant_id, exp_id[obs]);
                end else begin
                    check("rnd_extra_start", tx_start, 1'b0);
                end
                obs++;
                cur = tx_data;
                dly = $urandom_range(0, 3);
                ph  = 1;
            end
            if (ph == 1) begin
                check("rnd_start_hold", tx_start, 1'b1);
                if (dly == 0) begin
                    tx_busy = 1'b1;
                    hold    = $urandom_range(1, 5);
                    ph      = 2;
                end else begin
                    dly--;
                end
            end
            if (ph != 0) check("rnd_data_hold", tx_data, cur);
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() > 0) begin
                    b = rq[i][0];
                    drive(i, 1'b1, b[7:0], b[8]);
                end else begin
                    drive(i, 1'b0, 8'h00, 1'b0);
                end
            end
            #1;
            acc = req_valid & req_ready;
            check("rnd_ready_onehot", ($countones(req_ready) <= 1), 1'b1);
            if (acc != '0) check("rnd_no_timeout", lock_timeout, 1'b0);
            tick();
            cyc++;
        end
        check("rnd_bytes_seen", obs, exp_n);
        req_valid = '0;
        tx_busy   = 1'b0;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        tick();
        tick();
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_grant", grant_id, 2'd0);
        check("rst_locked", locked, 1'b0);
        check("rst_timeout", lock_timeout, 1'b0);
        rst = 1'b0;
        req_valid = '1;
        #1;
        check("rst_prio", req_ready, 4'b0001);
        req_valid = '0;
        tick();

        // Single byte from requester 2.
        drive(2, 1'b1, 8'h41, 1'b1);
        #1;
        check("sb_ready", req_ready, 4'b0100);
        tick();
        check("sb_ready_drop", req_ready, 4'b0000);
        check("sb_start", tx_start, 1'b1);
        check("sb_data", tx_data, 8'h41);
        check("sb_grant", grant_id, 2'd2);
        drive(2, 1'b0, 8'h00, 1'b0);
        repeat (2) tick();
        check("sb_start_held", tx_start, 1'b1);
        tx_busy = 1'b1;
        tick();
        check("sb_start_fall", tx_start, 1'b0);
        repeat (19) tick();
        check("sb_locked_busy", locked, 1'b1);
        tx_busy = 1'b0;
        tick();
        check("sb_unlocked", locked, 1'b0);
        check("sb_grant_kept", grant_id, 2'd2);

        // Packet lock: requester 1 sends three bytes while requester 0 waits.
        drive(1, 1'b1, 8'h10, 1'b0);
        #1;
        check("pk_rdy0", req_ready, 4'b0010);
        tick();
        check("pk_b0", tx_data, 8'h10);
        drive(0, 1'b1, 8'hA0, 1'b1);
        drive(1, 1'b1, 8'h11, 1'b0);
        serve(1, 2);
        #1;
        check("pk_rdy1", req_ready, 4'b0010);
        tick();
        check("pk_b1", tx_data, 8'h11);
        drive(1, 1'b1, 8'h12, 1'b1);
        serve(2, 1);
        #1;
        check("pk_rdy2", req_ready, 4'b0010);
        tick();
        check("pk_b2", tx_data, 8'h12);
        drive(1, 1'b0, 8'h00, 1'b0);
        serve(0, 3);
        #1;
        check("pk_rdy3", req_ready, 4'b0001);
        tick();
        check("pk_b3", tx_data, 8'hA0);
        check("pk_grant3", grant_id, 2'd0);
        drive(0, 1'b0, 8'h00, 1'b0);
        serve(1, 1);

        // Lock timeout: requester 3 leaves its packet open.
        drive(3, 1'b1, 8'h33, 1'b0);
        #1;
        check("to_rdy", req_ready, 4'b1000);
        tick();
        drive(3, 1'b0, 8'h00, 1'b0);
        drive(0, 1'b1, 8'h55, 1'b1);
        serve(0, 2);
        for (int k = 0; k < 8; k++) begin
            check("to_wait_ready", req_ready, 4'b0000);
            check("to_wait_pulse", lock_timeout, 1'b0);
            check("to_wait_locked", locked, 1'b1);
            tick();
        end
        check("to_pulse", lock_timeout, 1'b1);
        check("to_released", locked, 1'b0);
        check("to_rdy0", req_ready, 4'b0001);
        tick();
        check("to_pulse_end", lock_timeout, 1'b0);
        check("to_data", tx_data, 8'h55);
        check("to_grant", grant_id, 2'd0);
        drive(0, 1'b0, 8'h00, 1'b0);
        serve(1, 1);

        // Serializer busy while arbiter is idle blocks every ready.
        tx_busy = 1'b1;
        drive(0, 1'b1, 8'h66, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bi_ready", req_ready, 4'b0000);
            tick();
        end
        check("bi_no_start", tx_start, 1'b0);
        tx_busy = 1'b0;
        #1;
        check("bi_ready_rel", req_ready, 4'b0001);
        tick();
        check("bi_start", tx_start, 1'b1);
        check("bi_data", tx_data, 8'h66);
        drive(0, 1'b0, 8'h00, 1'b0);
        serve(0, 1);

        // Reset while locked in WAIT_DONE.
        drive(2, 1'b1, 8'h77, 1'b0);
        #1;
        check("mr_rdy", req_ready, 4'b0100);
        tick();
        drive(2, 1'b0, 8'h00, 1'b0);
        tx_busy = 1'b1;
        tick();
        check("mr_locked_pre", locked, 1'b1);
        rst = 1'b1;
        #1;
        check("mr_start", tx_start, 1'b0);
        check("mr_locked", locked, 1'b0);
        check("mr_grant", grant_id, 2'd0);
        tx_busy = 1'b0;
        #1;
        rst = 1'b0;
        req_valid = '1;
        #1;
        check("mr_prio", req_ready, 4'b0001);
        req_valid = '0;
        tick();

        mptr = N - 1;
        for (int r = 0; r < 4; r++) random_round();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
